// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends start/8 data/parity/stop,
// then checks the device ACK. Lines are driven open-drain through output enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 2000,
    parameter int TIMEOUT_CYC = 300000
) (
    input  logic       I_CLK,
    input  logic       I_RST,
    input  logic [7:0] I_TX_DATA,
    input  logic       I_TX_REQ,
    output logic       O_TX_BUSY,
    output logic       O_TX_DONE,
    output logic       O_TX_ERR,
    input  logic       I_PS2CLK,
    input  logic       I_PS2DATA,
    output logic       O_PS2CLK_OE,
    output logic       O_PS2DATA_OE,
    output logic       O_RX_INHIBIT
);

    localparam int INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [9:0]       shift_q, shift_d;
    logic             data_oe_q, data_oe_d;

    // Synchronisers reset to 1 (idle bus level) so reset release never fakes an edge.
    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic data_meta_q, data_sync_q;
    logic ps2_fall;
    logic timing_out;

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= I_PS2CLK;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= I_PS2DATA;
            data_sync_q <= data_meta_q;
        end
    end

    assign ps2_fall = clk_prev_q & ~clk_sync_q;

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q   <= S_IDLE;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            data_oe_q <= data_oe_d;
        end
    end

    assign timing_out = (to_cnt_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        data_oe_d = data_oe_q;

        case (state_q)
            S_IDLE: begin
                data_oe_d = 1'b0;
                if (I_TX_REQ) begin
                    state_d   = S_INHIBIT;
                    inh_cnt_d = '0;
                    shift_d   = {1'b1, ~^I_TX_DATA, I_TX_DATA};
                end
            end
            S_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    // Start bit goes out in the same cycle the clock is released.
                    state_d   = S_SEND;
                    data_oe_d = 1'b1;
                    bitcnt_d  = '0;
                    to_cnt_d  = '0;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            S_SEND: begin
                if (timing_out) begin
                    state_d   = S_ERR;
                    data_oe_d = 1'b0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (ps2_fall) begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[9:1]};
                        bitcnt_d  = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd9) begin
                            state_d = S_ACK;
                        end
                    end
                end
            end
            S_ACK: begin
                data_oe_d = 1'b0;
                if (timing_out) begin
                    state_d = S_ERR;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (ps2_fall) begin
                        state_d = data_sync_q ? S_ERR : S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                data_oe_d = 1'b0;
                if (timing_out) begin
                    state_d = S_ERR;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (clk_sync_q && data_sync_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
            S_ERR: begin
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // Decoded straight from state so an asynchronous reset releases the bus at once.
    assign O_TX_BUSY    = (state_q != S_IDLE);
    assign O_TX_DONE    = (state_q == S_DONE);
    assign O_TX_ERR     = (state_q == S_ERR);
    assign O_PS2CLK_OE  = (state_q == S_INHIBIT);
    assign O_PS2DATA_OE = data_oe_q;
    assign O_RX_INHIBIT = O_TX_BUSY;

endmodule
